// File: rtl/rca_pipe.sv
// ============================================================================
// rca_pipe -- parametrised, pipelined ripple-carry adder/subtractor.
//
// A WIDTH-bit add (or subtract) is split into STAGES chunks of CHUNK bits.
// Stage k ripples chunk k and registers its carry for stage k+1. Operands
// travel down the pipe alongside the beat. Completed low chunks of the
// result are carried forward unchanged. The last stage register is the
// output register, so a beat accepted at edge N is presented after edge
// N+STAGES-1. A valid/ready handshake stalls the whole pipe at once.
//
// Optional build macro:
//   RCA_PIPE_SAT_EN  - when defined, the final stage clamps the signed result
//                      to the most positive/negative value on overflow.
//
// Parameters:
//   WIDTH   operand/result width, a multiple of STAGES
//   STAGES  pipeline depth (number of chunks), 1..WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   pipe accepts a beat this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result (mod 2^WIDTH)
//   cout       carry out of the MSB (borrow-not when subtracting)
//   ovf        signed overflow
// ============================================================================
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // Per-stage registers; index STAGES-1 is the output stage.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Working values for the stage currently being evaluated in the loop.
    logic             advance;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] base_sum;
    logic             op_sub;
    logic             op_cin;
    logic             op_valid;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic             carry_into_msb;
    int               prev;

    // The output stage never forwards its operands or carry; they are kept
    // only so every stage has the same shape.
    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1],
                           carry_q[STAGES-1], sub_q[STAGES-1]};

    // Whole pipe moves together: it advances whenever the output slot is
    // empty or being drained this cycle.
    always_comb begin
        advance        = !valid_q[STAGES-1] || out_ready;
        op_a           = '0;
        op_b           = '0;
        base_sum       = '0;
        op_sub         = 1'b0;
        op_cin         = 1'b0;
        op_valid       = 1'b0;
        chunk_a        = '0;
        chunk_b        = '0;
        chunk_res      = '0;
        carry_into_msb = 1'b0;
        prev           = 0;
        cout_d         = cout_q;
        ovf_d          = ovf_q;

        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            sub_d[k]   = sub_q[k];
            carry_d[k] = carry_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            sum_d[k]   = sum_q[k];
        end

        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                prev = (k == 0) ? 0 : k - 1;
                if (k == 0) begin
                    // Subtraction forces the carry-in to 1 to complete ~b+1.
                    op_a     = a;
                    op_b     = b;
                    op_sub   = sub;
                    op_cin   = sub | cin;
                    op_valid = in_valid;
                    base_sum = '0;
                end else begin
                    op_a     = a_q[prev];
                    op_b     = b_q[prev];
                    op_sub   = sub_q[prev];
                    op_cin   = carry_q[prev];
                    op_valid = valid_q[prev];
                    base_sum = sum_q[prev];
                end

                chunk_a   = op_a[k*CHUNK +: CHUNK];
                chunk_b   = op_b[k*CHUNK +: CHUNK] ^ {CHUNK{op_sub}};
                chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b}
                          + {{CHUNK{1'b0}}, op_cin};

                valid_d[k] = op_valid;
                sub_d[k]   = op_sub;
                carry_d[k] = chunk_res[CHUNK];
                a_d[k]     = op_a;
                b_d[k]     = op_b;

                if (k == STAGES - 1) begin
                    // Result flags only move with a real beat; bubbles keep
                    // the last presented result on sum/cout/ovf.
                    if (op_valid) begin
                        carry_into_msb = chunk_res[CHUNK-1] ^ chunk_a[CHUNK-1]
                                       ^ chunk_b[CHUNK-1];
                        cout_d   = chunk_res[CHUNK];
                        ovf_d    = chunk_res[CHUNK] ^ carry_into_msb;
                        sum_d[k] = base_sum;
                        sum_d[k][k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
`ifdef RCA_PIPE_SAT_EN
                        // On overflow the true result has the sign of a.
                        if (ovf_d) begin
                            sum_d[k] = op_a[WIDTH-1]
                                     ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`endif
                    end
                end else begin
                    sum_d[k] = base_sum;
                    sum_d[k][k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sub_q[k]   <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                sub_q[k]   <= sub_d[k];
                carry_q[k] <= carry_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
            end
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
